// File: rtl/mem_bridge.sv
// Byte-wide bridge between the multicycle controller and a wait-stated external memory.
// Optional build macro BUS_TIMEOUT_EN adds a REQ timeout with a sticky buserr flag.
module mem_bridge #(
    parameter int WIDTH   = 8,
    parameter int MINWAIT = 0,
    parameter int TIMEOUT = 15
) (
    input  logic             ph1,
    input  logic             ph2,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] wd,
    input  logic             ext_rdy,
    input  logic [WIDTH-1:0] ext_rd,
    output logic [WIDTH-1:0] ext_adr,
    output logic [WIDTH-1:0] ext_wd,
    output logic             ext_re,
    output logic             ext_we,
    output logic [WIDTH-1:0] memdata,
    output logic             stall,
    output logic             buserr
);

    if (MINWAIT < 0 || MINWAIT > 15) begin : g_bad_minwait
        $error("mem_bridge: MINWAIT must be in 0..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_bridge: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        state_t           state;
        logic             wr;
        logic             re;
        logic             we;
        logic [7:0]       cnt;
        logic [WIDTH-1:0] adr;
        logic [WIDTH-1:0] wd;
        logic [WIDTH-1:0] memdata;
    } bridge_t;

    localparam logic [7:0] MINWAIT_C = 8'(MINWAIT);

    // m is the ph2 master latch, s the ph1 slave latch that everything reads.
    bridge_t m;
    bridge_t s;

    logic       req_any;
    logic [7:0] cnt_inc;
    logic       accept;

    assign req_any = memread | memwrite;
    assign cnt_inc = (s.cnt == 8'hFF) ? s.cnt : s.cnt + 8'd1;
    assign accept  = ext_rdy && (s.cnt >= MINWAIT_C);

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic buserr_m;
    logic buserr_s;
    logic tmo;

    // The counter reaching TIMEOUT on this update ends the access; ext_rdy still wins.
    assign tmo = (cnt_inc == TIMEOUT_C);

    always_ff @(negedge ph2) begin
        if (reset) begin
            buserr_m <= 1'b0;
        end else if (s.state == REQ && !accept && tmo) begin
            buserr_m <= 1'b1;
        end else begin
            buserr_m <= buserr_s;
        end
    end

    always_ff @(posedge ph1) begin
        buserr_s <= buserr_m;
    end

    assign buserr = buserr_s;
`else
    assign buserr = 1'b0;
`endif

    always_ff @(negedge ph2) begin
        if (reset) begin
            m.state   <= IDLE;
            m.wr      <= 1'b0;
            m.re      <= 1'b0;
            m.we      <= 1'b0;
            m.cnt     <= 8'd0;
            m.adr     <= '0;
            m.wd      <= '0;
            m.memdata <= '0;
        end else begin
            m <= s;
            case (s.state)
                IDLE: begin
                    if (req_any) begin
                        // Simultaneous read and write requests resolve to a write.
                        m.adr   <= adr;
                        m.wd    <= wd;
                        m.wr    <= memwrite;
                        m.re    <= ~memwrite;
                        m.we    <= memwrite;
                        m.cnt   <= 8'd0;
                        m.state <= REQ;
                    end
                end
                REQ: begin
                    m.cnt <= cnt_inc;
                    if (accept) begin
                        if (!s.wr) begin
                            m.memdata <= ext_rd;
                        end
                        m.re    <= 1'b0;
                        m.we    <= 1'b0;
                        m.state <= DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tmo) begin
                        if (!s.wr) begin
                            m.memdata <= '1;
                        end
                        m.re    <= 1'b0;
                        m.we    <= 1'b0;
                        m.state <= DONE;
                    end
`endif
                end
                DONE: begin
                    // Requests still asserted here belong to the access just finished.
                    m.cnt   <= 8'd0;
                    m.state <= IDLE;
                end
                default: begin
                    m.re    <= 1'b0;
                    m.we    <= 1'b0;
                    m.state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ph1) begin
        s <= m;
    end

    assign ext_adr = s.adr;
    assign ext_wd  = s.wd;
    assign ext_re  = s.re;
    assign ext_we  = s.we;
    assign memdata = s.memdata;
    assign stall   = (s.state == REQ) || ((s.state == IDLE) && req_any);

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: driver issues accesses, a monitor checks strobes,
// latched address/data, stall length and returned memdata against an expected queue.
module tb_mem_bridge;

    logic       ph1 = 1'b0;
    logic       ph2 = 1'b0;
    logic       reset = 1'b1;
    logic       memread = 1'b0;
    logic       memwrite = 1'b0;
    logic       ext_rdy = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] adr = 8'h00;
    logic [7:0] wd = 8'h00;
    logic [7:0] ext_rd = 8'h00;

    // dut: MINWAIT=0, TIMEOUT=4; dut_mw: MINWAIT=2. sel routes requests and monitoring.
    logic       a_memread, a_memwrite, b_memread, b_memwrite;
    logic [7:0] a_ext_adr, a_ext_wd, a_memdata, b_ext_adr, b_ext_wd, b_memdata;
    logic       a_ext_re, a_ext_we, a_stall, a_buserr, b_ext_re, b_ext_we, b_stall, b_buserr;

    assign a_memread  = memread & ~sel;
    assign a_memwrite = memwrite & ~sel;
    assign b_memread  = memread & sel;
    assign b_memwrite = memwrite & sel;

    mem_bridge #(.WIDTH(8), .MINWAIT(0), .TIMEOUT(4)) dut (
        .ph1(ph1), .ph2(ph2), .reset(reset),
        .memread(a_memread), .memwrite(a_memwrite), .adr(adr), .wd(wd),
        .ext_rdy(ext_rdy), .ext_rd(ext_rd),
        .ext_adr(a_ext_adr), .ext_wd(a_ext_wd), .ext_re(a_ext_re), .ext_we(a_ext_we),
        .memdata(a_memdata), .stall(a_stall), .buserr(a_buserr)
    );

    mem_bridge #(.WIDTH(8), .MINWAIT(2), .TIMEOUT(15)) dut_mw (
        .ph1(ph1), .ph2(ph2), .reset(reset),
        .memread(b_memread), .memwrite(b_memwrite), .adr(adr), .wd(wd),
        .ext_rdy(ext_rdy), .ext_rd(ext_rd),
        .ext_adr(b_ext_adr), .ext_wd(b_ext_wd), .ext_re(b_ext_re), .ext_we(b_ext_we),
        .memdata(b_memdata), .stall(b_stall), .buserr(b_buserr)
    );

    logic [7:0] mon_ext_adr, mon_ext_wd, mon_memdata;
    logic       mon_ext_re, mon_ext_we, mon_stall, mon_buserr;

    assign mon_ext_adr = sel ? b_ext_adr : a_ext_adr;
    assign mon_ext_wd  = sel ? b_ext_wd  : a_ext_wd;
    assign mon_memdata = sel ? b_memdata : a_memdata;
    assign mon_ext_re  = sel ? b_ext_re  : a_ext_re;
    assign mon_ext_we  = sel ? b_ext_we  : a_ext_we;
    assign mon_stall   = sel ? b_stall   : a_stall;
    assign mon_buserr  = sel ? b_buserr  : a_buserr;

    // ---------------- clock / reset ----------------
    initial begin
        forever begin
            #1 ph1 = 1'b1;
            #8 ph1 = 1'b0;
            #2 ph2 = 1'b1;
            #8 ph2 = 1'b0;
            #1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] adr;
        logic [7:0] wd;
        logic [7:0] data;
        logic       wr;
        int         stall_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: samples mid-ph2, away from the ph2-fall/ph1-rise update edges.
    int mon_busy = 0;
    int mon_stall_n = 0;
    int mon_strobe_n = 0;

    always begin
        @(posedge ph2);
        #1;
        if (reset) begin
            if (mon_busy != 0 && exp_q.size() > 0) void'(exp_q.pop_front());
            mon_busy = 0;
            mon_stall_n = 0;
            mon_strobe_n = 0;
        end else begin
            if (mon_ext_re || mon_ext_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(mon_ext_re | mon_ext_we), 32'd0);
                end else begin
                    check("ext_re", 32'(mon_ext_re), 32'(!exp_q[0].wr));
                    check("ext_we", 32'(mon_ext_we), 32'(exp_q[0].wr));
                    check("ext_adr", 32'(mon_ext_adr), 32'(exp_q[0].adr));
                    if (exp_q[0].wr) check("ext_wd", 32'(mon_ext_wd), 32'(exp_q[0].wd));
                end
                mon_strobe_n++;
            end
            if (mon_stall) begin
                mon_busy = 1;
                mon_stall_n++;
            end else if (mon_busy != 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("memdata", 32'(mon_memdata), 32'(e.data));
                    check("stall_cycles", 32'(mon_stall_n), 32'(e.stall_cycles));
                    check("strobe_cycles", 32'(mon_strobe_n), 32'(e.stall_cycles - 1));
                end
                mon_busy = 0;
                mon_stall_n = 0;
                mon_strobe_n = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge ph1);
        #1;
    endtask

    task automatic sample();
        @(posedge ph2);
        #2;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        memread = 1'b0;
        memwrite = 1'b0;
        ext_rdy = 1'b0;
        repeat (n) next_cycle();
        reset = 1'b0;
    endtask

    task automatic go_idle();
        next_cycle();
        memread = 1'b0;
        memwrite = 1'b0;
        ext_rdy = 1'b0;
    endtask

    // low = REQ cycles with ext_rdy low before it rises (255 = never).
    task automatic access(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] rd, input int low,
                          input logic [7:0] exp_data, input int exp_stall);
        int  k;
        bit  done;
        exp_q.push_back('{adr: a, wd: d, data: exp_data, wr: wr, stall_cycles: exp_stall});
        next_cycle();
        memread = ~wr;
        memwrite = wr;
        adr = a;
        wd = d;
        ext_rd = rd;
        ext_rdy = (low == 0);
        k = 0;
        done = 1'b0;
        while (!done && k < 60) begin
            sample();
            if (!mon_stall && k > 0) begin
                done = 1'b1;
            end else begin
                next_cycle();
                k++;
                ext_rdy = ((k - 1) >= low);
            end
        end
        if (!done) check("access_wait_bound", 32'(k), 32'd0);
    endtask

    logic [7:0] rd_tab[4];

    initial begin
        rd_tab[0] = 8'h11;
        rd_tab[1] = 8'h22;
        rd_tab[2] = 8'h33;
        rd_tab[3] = 8'h44;

        do_reset(3);
        sample();
        check("rst_ext_re", 32'(a_ext_re), 32'd0);
        check("rst_ext_we", 32'(a_ext_we), 32'd0);
        check("rst_stall", 32'(a_stall), 32'd0);
        check("rst_memdata", 32'(a_memdata), 32'd0);
        check("rst_ext_adr", 32'(a_ext_adr), 32'd0);
        check("rst_ext_wd", 32'(a_ext_wd), 32'd0);
        check("rst_buserr", 32'(a_buserr), 32'd0);

        // Single read, memory ready immediately.
        access(1'b0, 8'h10, 8'h00, 8'hA5, 0, 8'hA5, 2);
        go_idle();

        // Write with three wait states; memdata keeps the last read byte.
        access(1'b1, 8'h20, 8'h3C, 8'h00, 3, 8'hA5, 5);
        go_idle();

        // Back-to-back reads: request stays high through each DONE.
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 8'(i), 8'h00, rd_tab[i], 0, rd_tab[i], 2);
        end
        go_idle();
        sample();
        check("buserr_after_reads", 32'(mon_buserr), 32'd0);

        // MINWAIT=2 instance.
        sel = 1'b1;
        access(1'b0, 8'h55, 8'h00, 8'h66, 0, 8'h66, 4);
        go_idle();
        sel = 1'b0;

        // Reset in the second REQ cycle of a read.
        exp_q.push_back('{adr: 8'h30, wd: 8'h00, data: 8'h00, wr: 1'b0, stall_cycles: 0});
        next_cycle();
        memread = 1'b1;
        adr = 8'h30;
        ext_rd = 8'h99;
        ext_rdy = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        memread = 1'b0;
        sample();
        check("abort_ext_re", 32'(a_ext_re), 32'd0);
        check("abort_stall", 32'(a_stall), 32'd0);
        check("abort_memdata", 32'(a_memdata), 32'd0);

`ifdef BUS_TIMEOUT_EN
        access(1'b0, 8'h40, 8'h00, 8'h12, 255, 8'hFF, 5);
        go_idle();
        sample();
        check("buserr_set", 32'(a_buserr), 32'd1);
        access(1'b0, 8'h41, 8'h00, 8'h77, 0, 8'h77, 2);
        go_idle();
        sample();
        check("buserr_sticky", 32'(a_buserr), 32'd1);
        do_reset(2);
        sample();
        check("buserr_cleared", 32'(a_buserr), 32'd0);
`else
        access(1'b0, 8'h41, 8'h00, 8'h77, 0, 8'h77, 2);
        go_idle();
        sample();
        check("buserr_tied", 32'(a_buserr), 32'd0);
`endif

        repeat (2) next_cycle();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Byte-wide memory bridge between the multicycle controller/datapath and external memory.
- Handles external memory with a ready handshake and a variable number of wait states.
- Consumes the controller's memread/memwrite strobes plus the datapath address and write data; drives the external bus; returns registered read data.
- Asserts stall, which freezes the controller state latches and datapath enables until the access completes.

Parameters:
- WIDTH, 8, data and address width in bits.
- MINWAIT, 0, minimum REQ cycles before ext_rdy is accepted (0..15).
- TIMEOUT, 15, REQ cycles without ext_rdy before forced completion (1..255); used only with BUS_TIMEOUT_EN.

Ports:
- ph1  in  1  two-phase clock, slave phase.
- ph2  in  1  two-phase clock, master phase.
- reset  in  1  reset, synchronous, active-high.
- memread  in  1  read request from controller.
- memwrite  in  1  write request from controller.
- adr  in  WIDTH  byte address from datapath.
- wd  in  WIDTH  write data from datapath.
- ext_rdy  in  1  external memory ready / data valid.
- ext_rd  in  WIDTH  external read data.
- ext_adr  out  WIDTH  latched address to external memory.
- ext_wd  out  WIDTH  latched write data to external memory.
- ext_re  out  1  external read strobe.
- ext_we  out  1  external write strobe.
- memdata  out  WIDTH  read data to instruction register and MDR.
- stall  out  1  hold controller and datapath.
- buserr  out  1  sticky timeout flag; tied 0 without BUS_TIMEOUT_EN.

Behaviour:
- Cycle = one ph1/ph2 period. State is held in a ph2 master latch followed by a ph1 slave latch, matching the controller.
- All state updates and reset are sampled on the ph2/ph1 pair.
- Reset values:
  - state IDLE, ext_adr 0, ext_wd 0, memdata 0, buserr 0, wait counter 0.
  - ext_re, ext_we and stall are all 0.
- Reset mid-access: abandon the access and return to IDLE. Strobes drop on the first update with reset high. No memdata update and no external completion.
- State IDLE:
  - If memread or memwrite is high: stall=1 combinationally in that same cycle.
  - In that cycle, latch adr into ext_adr and wd into ext_wd, record the direction, and go to REQ.
  - If memread and memwrite are both high: treat as write.
  - Otherwise stall=0.
- State REQ:
  - stall=1.
  - ext_re=1 for a read, ext_we=1 for a write. Strobes are decoded from registered state only (glitch-free).
  - ext_adr and ext_wd are held stable.
  - The wait counter increments each REQ cycle and saturates at 255.
  - If ext_rdy=1 and counter>=MINWAIT: on a read, latch ext_rd into memdata; go to DONE.
  - Otherwise stay in REQ.
- State DONE:
  - stall=0, strobes 0; memdata holds its value. The consumer captures memdata this cycle.
  - Request inputs in this cycle belong to the access just serviced and are ignored.
  - Go to IDLE; clear the wait counter.
- Latency: with MINWAIT=0 and ext_rdy already high, an access costs 2 stall cycles (IDLE detect, REQ), then DONE.
  - Each extra cycle of ext_rdy low adds one stall cycle.
- Back-to-back requests (FETCH1..FETCH4) are each serviced separately: IDLE→REQ→DONE→IDLE per byte.
- memdata changes only on read completion. Writes never alter memdata.
- ext_rdy outside REQ is ignored.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - In REQ, if the counter reaches TIMEOUT with no accepted ext_rdy, go to DONE.
  - On a read timeout, memdata = all ones (8'hFF).
  - A write timeout is dropped.
  - buserr is set and stays 1 until reset.
  - ext_rdy in the same cycle as the timeout wins (normal completion, no buserr).
- Undefined: REQ waits indefinitely; buserr is constant 0; no timeout logic is generated.

Test Plan:
- Reset, then memread=1, adr=8'h10, ext_rdy=1, ext_rd=8'hA5.
  -> stall=1 for 2 cycles, ext_re=1 in the REQ cycle, ext_adr=8'h10, memdata=8'hA5 in DONE with stall=0.
- memwrite=1, adr=8'h20, wd=8'h3C, ext_rdy low for 3 REQ cycles then high.
  -> ext_we=1 for 4 cycles with ext_adr=8'h20 and ext_wd=8'h3C stable, stall=1 for 5 cycles, memdata unchanged.
- Four consecutive reads at adr 0..3 returning 8'h11, 8'h22, 8'h33, 8'h44.
  -> four separate IDLE/REQ/DONE sequences; memdata in each DONE equals the matching byte; no request is skipped or duplicated.
- MINWAIT=2, read with ext_rdy high throughout.
  -> ext_ready is accepted only once counter>=2, so stall=1 for 4 cycles total.
- Reset asserted in the second REQ cycle of a read.
  -> ext_re=0, stall=0, state IDLE on the next cycle; memdata stays 0.
- BUS_TIMEOUT_EN, TIMEOUT=4, read with ext_rdy held 0.
  -> DONE after 4 REQ cycles, memdata=8'hFF, buserr=1 and stays 1 through later successful accesses until reset.
